// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares one synchronous FIFO write port among NUM_REQ producers. Arbitration
//   is round-robin and locked per packet. Each accepted beat is written as
//   {grant_id, payload}, so the downstream FIFO needs a width of
//   DATA_WIDTH + ID_W and the consumer can demultiplex by source.
//
// Parameters
//   NUM_REQ     number of requesters (>= 2)
//   DATA_WIDTH  payload width per requester
//   MAX_BEATS   beats per grant before a forced release (>= 1)
//   ID_W        source tag width, $clog2(NUM_REQ) (derived)
//
// Ports
//   clk             clock
//   rstn            synchronous active-low reset
//   i_req_valid     per-requester beat valid
//   i_req_last      per-requester last beat of packet
//   i_req_data      payloads; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready     per-requester beat accepted (combinational)
//   i_fifo_full     FIFO full flag
//   o_fifo_w_en     FIFO write enable (combinational)
//   o_fifo_data_in  {grant_id, payload} (combinational)
//   o_grant_id      current owner (registered, holds its value in IDLE)
//   o_busy          high while a grant is held (XFER)
//   o_stat_beats    per-requester 16-bit saturating accepted-beat counters,
//                   present only when FIFO_ARB_STATS_EN is defined
//
// Optional feature macro: FIFO_ARB_STATS_EN
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BEATS  = 16,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_w_en,
  output logic [DATA_WIDTH+ID_W-1:0]    o_fifo_data_in,
  output logic [ID_W-1:0]               o_grant_id,
  output logic                          o_busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         o_stat_beats
`endif
);

  // Beat counter must hold 0..MAX_BEATS-1 and stay at least one bit wide.
  localparam int unsigned CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_grant;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic               r_busy;

  logic               w_any_req;
  logic [ID_W-1:0]    w_pick;
  logic               w_own_valid;
  logic               w_own_last;
  logic [DATA_WIDTH-1:0] w_own_data;
  logic               w_ready;
  logic               w_xfer;
  logic               w_cnt_max;
  logic               w_release;
  logic [ID_W-1:0]    w_next_ptr;

  // Round-robin pick: first valid requester scanning from r_rr_ptr upward.
  always_comb begin
    int unsigned idx;
    logic        found;
    w_pick    = '0;
    w_any_req = |i_req_valid;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && i_req_valid[ID_W'(idx)]) begin
        w_pick = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

  // Owner-side view of the request bus.
  assign w_own_valid = i_req_valid[r_grant];
  assign w_own_last  = i_req_last[r_grant];
  assign w_own_data  = i_req_data[r_grant*DATA_WIDTH +: DATA_WIDTH];

  // Ready is gated by rstn so nothing is written while reset is asserted.
  assign w_ready   = rstn & (r_state == S_XFER) & ~i_fifo_full;
  assign w_xfer    = w_ready & w_own_valid;
  assign w_cnt_max = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
  // Last beat and beat limit coinciding still gives a single release.
  assign w_release = w_xfer & (w_own_last | w_cnt_max);

  assign w_next_ptr = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + ID_W'(1);

  // Write-side outputs: the FIFO captures the beat at the same edge.
  assign o_req_ready    = w_ready ? (NUM_REQ'(1) << r_grant) : '0;
  assign o_fifo_w_en    = w_xfer;
  assign o_fifo_data_in = {r_grant, w_own_data};
  assign o_grant_id     = r_grant;
  assign o_busy         = r_busy;

  // Arbitration FSM with its registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_pick;
            r_state <= S_XFER;
            r_busy  <= 1'b1;
          end
        end
        S_XFER: begin
          // Owner keeps the grant through bubbles and full stalls.
          if (w_release) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_rr_ptr   <= w_next_ptr;
            r_beat_cnt <= '0;
          end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_stat [NUM_REQ];

  // Per-requester accepted-beat counters, saturating at 16'hFFFF.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!rstn) begin
        r_stat[i] <= '0;
      end else if (w_xfer && (r_grant == ID_W'(i)) && (r_stat[i] != 16'hFFFF)) begin
        r_stat[i] <= r_stat[i] + 16'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat_out
    assign o_stat_beats[gi*16 +: 16] = r_stat[gi];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BEATS=16).
//   Producers are beat lists per requester; the run task plays them cycle by
//   cycle and records a per-cycle trace that each scenario task compares
//   against hand-computed cycle numbers and data.
//   Define FIFO_ARB_STATS_EN to also check the beat counters.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MB   = 16;
  localparam int IW   = 2;
  localparam int MAXC = 128;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NR-1:0]     i_req_valid;
  logic [NR-1:0]     i_req_last;
  logic [NR*DW-1:0]  i_req_data;
  logic [NR-1:0]     o_req_ready;
  logic              i_fifo_full;
  logic              o_fifo_w_en;
  logic [DW+IW-1:0]  o_fifo_data_in;
  logic [IW-1:0]     o_grant_id;
  logic              o_busy;
`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0]  o_stat_beats;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_req_valid    (i_req_valid),
    .i_req_last     (i_req_last),
    .i_req_data     (i_req_data),
    .o_req_ready    (o_req_ready),
    .i_fifo_full    (i_fifo_full),
    .o_fifo_w_en    (o_fifo_w_en),
    .o_fifo_data_in (o_fifo_data_in),
    .o_grant_id     (o_grant_id),
    .o_busy         (o_busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .o_stat_beats   (o_stat_beats)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Producer beat lists.
  logic [DW-1:0] bdata [NR][32];
  logic          blast [NR][32];
  int            nb    [NR];
  int            pos   [NR];

  // Cycle windows (relative to cyc) for fifo_full high and rstn low.
  int full_from, full_to, rst_from, rst_to;

  // Per-cycle trace sampled at the falling edge.
  logic          tr_wen   [MAXC];
  logic [NR-1:0] tr_ready [MAXC];
  logic [IW-1:0] tr_grant [MAXC];
  logic          tr_busy  [MAXC];
  logic [DW+IW-1:0] tr_data [MAXC];
`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0] tr_stat [MAXC];
`endif

  task automatic clear_producers();
    for (int i = 0; i < NR; i++) begin
      nb[i]  = 0;
      pos[i] = 0;
    end
    full_from = -1; full_to = -1;
    rst_from  = -1; rst_to  = -1;
  endtask

  task automatic load(input int r, input logic [DW-1:0] d, input logic l);
    bdata[r][nb[r]] = d;
    blast[r][nb[r]] = l;
    nb[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (pos[i] < nb[i]) begin
        i_req_valid[i]         = 1'b1;
        i_req_last[i]          = blast[i][pos[i]];
        i_req_data[i*DW +: DW] = bdata[i][pos[i]];
      end else begin
        i_req_valid[i]         = 1'b0;
        i_req_last[i]          = 1'b0;
        i_req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  // Plays n cycles: drive after the rising edge, sample at the falling edge.
  task automatic run(input int n);
    repeat (n) begin
      rstn        = !(cyc >= rst_from && cyc < rst_to);
      i_fifo_full = (cyc >= full_from && cyc < full_to);
      drive();
      @(negedge clk);
      if (cyc < MAXC) begin
        tr_wen[cyc]   = o_fifo_w_en;
        tr_ready[cyc] = o_req_ready;
        tr_grant[cyc] = o_grant_id;
        tr_busy[cyc]  = o_busy;
        tr_data[cyc]  = o_fifo_data_in;
`ifdef FIFO_ARB_STATS_EN
        tr_stat[cyc]  = o_stat_beats;
`endif
      end
      for (int i = 0; i < NR; i++) begin
        if (!rstn) nb[i] = pos[i];  // reset abandons any pending packet
        else if (i_req_valid[i] && o_req_ready[i]) pos[i]++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    clear_producers();
    i_fifo_full = 1'b0;
    i_req_valid = '1;  // requests during reset must not be accepted
    i_req_last  = '1;
    i_req_data  = '1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (o_fifo_w_en !== 1'b0) begin bad++; $display("FAIL rst_wen got=%b exp=0", o_fifo_w_en); end
    total++; if (o_req_ready !== 4'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0000", o_req_ready); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    total++; if (o_grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant got=%0d exp=0", o_grant_id); end
`ifdef FIFO_ARB_STATS_EN
    total++; if (o_stat_beats !== '0) begin bad++; $display("FAIL rst_stat got=%h exp=0", o_stat_beats); end
`endif
    clear_producers();
    cyc = 0;
    run(10);
    for (int c = 0; c < 10; c++) begin
      total++; if (tr_wen[c] !== 1'b0) begin bad++; $display("FAIL idle_wen c=%0d got=%b exp=0", c, tr_wen[c]); end
      total++; if (tr_ready[c] !== 4'b0) begin bad++; $display("FAIL idle_ready c=%0d got=%b exp=0000", c, tr_ready[c]); end
      total++; if (tr_busy[c] !== 1'b0) begin bad++; $display("FAIL idle_busy c=%0d got=%b exp=0", c, tr_busy[c]); end
    end
  endtask

  task automatic test_single_packet();
    logic [DW+IW-1:0] exp_d [3];
    exp_d[0] = {2'd2, 8'hA1};
    exp_d[1] = {2'd2, 8'hA2};
    exp_d[2] = {2'd2, 8'hA3};
    apply_reset();
    clear_producers();
    cyc = 0;
    load(2, 8'hA1, 1'b0);
    load(2, 8'hA2, 1'b0);
    load(2, 8'hA3, 1'b1);
    run(6);
    total++; if (tr_wen[0] !== 1'b0) begin bad++; $display("FAIL sp_arb_lat got=%b exp=0", tr_wen[0]); end
    for (int c = 1; c <= 3; c++) begin
      total++; if (tr_wen[c] !== 1'b1) begin bad++; $display("FAIL sp_wen c=%0d got=%b exp=1", c, tr_wen[c]); end
      total++; if (tr_data[c] !== exp_d[c-1]) begin bad++; $display("FAIL sp_data c=%0d got=%h exp=%h", c, tr_data[c], exp_d[c-1]); end
      total++; if (tr_grant[c] !== 2'd2) begin bad++; $display("FAIL sp_grant c=%0d got=%0d exp=2", c, tr_grant[c]); end
      total++; if (tr_ready[c] !== 4'b0100) begin bad++; $display("FAIL sp_ready c=%0d got=%b exp=0100", c, tr_ready[c]); end
    end
    total++; if (tr_busy[4] !== 1'b0 || tr_wen[4] !== 1'b0) begin bad++; $display("FAIL sp_release got busy=%b wen=%b exp 0 0", tr_busy[4], tr_wen[4]); end
`ifdef FIFO_ARB_STATS_EN
    total++; if (tr_stat[4] !== {16'd0, 16'd3, 16'd0, 16'd0}) begin bad++; $display("FAIL sp_stat got=%h exp=%h", tr_stat[4], {16'd0, 16'd3, 16'd0, 16'd0}); end
`endif
    // rr_ptr is now 3: with 0 and 3 both requesting, 3 must win first.
    load(0, 8'h10, 1'b1);
    load(3, 8'h30, 1'b1);
    run(6);
    total++; if (tr_wen[7] !== 1'b1 || tr_data[7] !== {2'd3, 8'h30}) begin bad++; $display("FAIL sp_ptr_first got wen=%b data=%h exp 1 %h", tr_wen[7], tr_data[7], {2'd3, 8'h30}); end
    total++; if (tr_wen[8] !== 1'b0) begin bad++; $display("FAIL sp_gap got=%b exp=0", tr_wen[8]); end
    total++; if (tr_wen[9] !== 1'b1 || tr_data[9] !== {2'd0, 8'h10}) begin bad++; $display("FAIL sp_ptr_second got wen=%b data=%h exp 1 %h", tr_wen[9], tr_data[9], {2'd0, 8'h10}); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    clear_producers();
    cyc = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NR; i++) begin
        load(i, 8'(i*16 + p*2),     1'b0);
        load(i, 8'(i*16 + p*2 + 1), 1'b1);
      end
    run(26);
    // Packet p occupies cycles 3p+1, 3p+2; cycle 3p is the arbitration gap.
    for (int k = 0; k < 16; k++) begin
      int p, c, id;
      logic [DW+IW-1:0] exp_d;
      p  = k / 2;
      c  = 3*p + 1 + (k % 2);
      id = p % 4;
      exp_d = {2'(id), 8'(id*16 + (p/4)*2 + (k % 2))};
      total++; if (tr_wen[c] !== 1'b1 || tr_data[c] !== exp_d) begin bad++; $display("FAIL rr_beat k=%0d c=%0d got wen=%b data=%h exp 1 %h", k, c, tr_wen[c], tr_data[c], exp_d); end
    end
    for (int p = 1; p < 8; p++) begin
      total++; if (tr_wen[3*p] !== 1'b0 || tr_busy[3*p] !== 1'b0) begin bad++; $display("FAIL rr_gap c=%0d got wen=%b busy=%b exp 0 0", 3*p, tr_wen[3*p], tr_busy[3*p]); end
    end
    total++; if (tr_wen[24] !== 1'b0) begin bad++; $display("FAIL rr_end got=%b exp=0", tr_wen[24]); end
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] bv [4];
    bv[0] = 8'hB0; bv[1] = 8'hB1; bv[2] = 8'hB2; bv[3] = 8'hB3;
    apply_reset();
    clear_producers();
    cyc = 0;
    for (int j = 0; j < 4; j++) load(1, bv[j], (j == 3));
    full_from = 2;
    full_to   = 7;
    run(12);
    total++; if (tr_wen[1] !== 1'b1 || tr_data[1] !== {2'd1, 8'hB0}) begin bad++; $display("FAIL ff_first got wen=%b data=%h exp 1 %h", tr_wen[1], tr_data[1], {2'd1, 8'hB0}); end
    for (int c = 2; c <= 6; c++) begin
      total++; if (tr_wen[c] !== 1'b0) begin bad++; $display("FAIL ff_wen c=%0d got=%b exp=0", c, tr_wen[c]); end
      total++; if (tr_ready[c] !== 4'b0) begin bad++; $display("FAIL ff_ready c=%0d got=%b exp=0000", c, tr_ready[c]); end
      total++; if (tr_grant[c] !== 2'd1 || tr_busy[c] !== 1'b1) begin bad++; $display("FAIL ff_hold c=%0d got grant=%0d busy=%b exp 1 1", c, tr_grant[c], tr_busy[c]); end
    end
    for (int c = 7; c <= 9; c++) begin
      total++; if (tr_wen[c] !== 1'b1 || tr_data[c] !== {2'd1, bv[c-6]}) begin bad++; $display("FAIL ff_resume c=%0d got wen=%b data=%h exp 1 %h", c, tr_wen[c], tr_data[c], {2'd1, bv[c-6]}); end
    end
    total++; if (tr_busy[10] !== 1'b0) begin bad++; $display("FAIL ff_release got=%b exp=0", tr_busy[10]); end
  endtask

  task automatic test_max_beats();
    apply_reset();
    clear_producers();
    cyc = 0;
    for (int j = 0; j < 20; j++) load(0, 8'(j + 1), 1'b0);
    load(3, 8'h3C, 1'b1);
    run(27);
    for (int c = 1; c <= 16; c++) begin
      total++; if (tr_wen[c] !== 1'b1 || tr_data[c] !== {2'd0, 8'(c)}) begin bad++; $display("FAIL mb_first c=%0d got wen=%b data=%h exp 1 %h", c, tr_wen[c], tr_data[c], {2'd0, 8'(c)}); end
    end
    total++; if (tr_wen[17] !== 1'b0 || tr_busy[17] !== 1'b0) begin bad++; $display("FAIL mb_release got wen=%b busy=%b exp 0 0", tr_wen[17], tr_busy[17]); end
    total++; if (tr_wen[18] !== 1'b1 || tr_data[18] !== {2'd3, 8'h3C}) begin bad++; $display("FAIL mb_other got wen=%b data=%h exp 1 %h", tr_wen[18], tr_data[18], {2'd3, 8'h3C}); end
    total++; if (tr_wen[19] !== 1'b0) begin bad++; $display("FAIL mb_gap got=%b exp=0", tr_wen[19]); end
    for (int c = 20; c <= 23; c++) begin
      total++; if (tr_wen[c] !== 1'b1 || tr_data[c] !== {2'd0, 8'(c - 3)}) begin bad++; $display("FAIL mb_rest c=%0d got wen=%b data=%h exp 1 %h", c, tr_wen[c], tr_data[c], {2'd0, 8'(c - 3)}); end
    end
    // No last yet: req 0 keeps the grant through the bubble.
    for (int c = 24; c <= 26; c++) begin
      total++; if (tr_wen[c] !== 1'b0 || tr_busy[c] !== 1'b1 || tr_grant[c] !== 2'd0) begin bad++; $display("FAIL mb_lock c=%0d got wen=%b busy=%b grant=%0d exp 0 1 0", c, tr_wen[c], tr_busy[c], tr_grant[c]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    clear_producers();
    cyc = 0;
    load(1, 8'h11, 1'b1);
    load(2, 8'hC0, 1'b0);
    load(2, 8'hC1, 1'b0);
    load(2, 8'hC2, 1'b0);
    load(2, 8'hC3, 1'b1);
    rst_from = 4;
    rst_to   = 6;
    run(6);
    total++; if (tr_wen[1] !== 1'b1 || tr_data[1] !== {2'd1, 8'h11}) begin bad++; $display("FAIL rm_pre got wen=%b data=%h exp 1 %h", tr_wen[1], tr_data[1], {2'd1, 8'h11}); end
    total++; if (tr_wen[3] !== 1'b1 || tr_data[3] !== {2'd2, 8'hC0}) begin bad++; $display("FAIL rm_beat1 got wen=%b data=%h exp 1 %h", tr_wen[3], tr_data[3], {2'd2, 8'hC0}); end
    for (int c = 4; c <= 5; c++) begin
      total++; if (tr_wen[c] !== 1'b0 || tr_ready[c] !== 4'b0) begin bad++; $display("FAIL rm_gate c=%0d got wen=%b ready=%b exp 0 0000", c, tr_wen[c], tr_ready[c]); end
    end
    total++; if (tr_busy[5] !== 1'b0 || tr_grant[5] !== 2'd0) begin bad++; $display("FAIL rm_state got busy=%b grant=%0d exp 0 0", tr_busy[5], tr_grant[5]); end
`ifdef FIFO_ARB_STATS_EN
    total++; if (tr_stat[5] !== '0) begin bad++; $display("FAIL rm_stat got=%h exp=0", tr_stat[5]); end
`endif
    rst_from = -1;
    rst_to   = -1;
    load(0, 8'hD0, 1'b1);
    load(2, 8'hD2, 1'b1);
    run(6);
    total++; if (tr_wen[6] !== 1'b0) begin bad++; $display("FAIL rm_no_tail got=%b exp=0", tr_wen[6]); end
    total++; if (tr_wen[7] !== 1'b1 || tr_data[7] !== {2'd0, 8'hD0}) begin bad++; $display("FAIL rm_ptr0 got wen=%b data=%h exp 1 %h", tr_wen[7], tr_data[7], {2'd0, 8'hD0}); end
    total++; if (tr_wen[9] !== 1'b1 || tr_data[9] !== {2'd2, 8'hD2}) begin bad++; $display("FAIL rm_next got wen=%b data=%h exp 1 %h", tr_wen[9], tr_data[9], {2'd2, 8'hD2}); end
  endtask

  initial begin
    rstn        = 1'b0;
    i_fifo_full = 1'b0;
    i_req_valid = '0;
    i_req_last  = '0;
    i_req_data  = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_fifo_full();
    test_max_beats();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
